lookup_table_writer: RTL and testbench
======================================

// Module: lookup_table_writer
// PURPOSE
//  Control-plane writer for one pipeline stage: parses config commands from an AXI4-Stream
//  slave port and drives the lookup engine's control channel (TCAM entry data/mask/addr/en)
//  and action-RAM write port (action_data_in/en/addr). Sits between the config-packet
//  demux and one stage's lookup engine; commands addressed to another stage are discarded.
// PARAMETERS
//  C_S_AXIS_DATA_WIDTH  256   config stream beat width; ENTRY_LEN must be a multiple of it
//  ENTRY_LEN            1024  TCAM entry data/mask width
//  ACT_LEN              25    action word width
//  ADDR_W               4     table address width (16 entries)
//  STAGE                0     stage id this writer accepts (4-bit compare)
// PORTS
//  axis_clk         in   1     clock
//  aresetn          in   1     async active-low reset
//  s_axis_tdata     in   256   config beat
//  s_axis_tvalid    in   1     beat valid
//  s_axis_tlast     in   1     last beat of command
//  s_axis_tready    out  1     beat accepted when tvalid&tready
//  lookup_din       out  1024  TCAM entry data
//  lookup_din_mask  out  1024  TCAM entry mask
//  lookup_din_addr  out  4     TCAM write address
//  lookup_din_en    out  1     TCAM write strobe, 1-cycle pulse
//  action_data_in   out  25    action word
//  action_addr      out  4     action-RAM write address
//  action_en        out  1     action-RAM write strobe, 1-cycle pulse
//  cfg_err          out  1     1-cycle pulse on malformed command
//  cfg_cnt          out  16    committed commands, wraps 0xFFFF->0
// BEHAVIOUR
//  - Header beat: [255:248] opcode, [247:244] stage, [243:240] addr, [24:0] action.
//    Opcode 0x01 = entry+action write: header, 4 data beats, 4 mask beats (9 beats), tlast on beat 9.
//    Opcode 0x02 = action-only write: header alone, tlast on it.
//  - Data beat k (k=0..3) -> lookup_din[256k+255:256k]; mask beat k likewise into lookup_din_mask.
//  - FSM: IDLE (await header), DATA (beat cnt 0..3), MASK (cnt 0..3), COMMIT, DRAIN.
//  - IDLE: stage!=STAGE -> DRAIN (no err); unknown opcode -> cfg_err, DRAIN; opcode 0x02 with
//    tlast -> COMMIT; opcode 0x02 without tlast -> cfg_err, DRAIN; opcode 0x01 with tlast ->
//    cfg_err, stay IDLE; opcode 0x01 without tlast -> DATA. Any header accepted with tlast=1
//    that is not committed returns to IDLE instead of DRAIN.
//  - DATA/MASK: tlast before 4th mask beat -> cfg_err, IDLE, no write. 4th mask beat with
//    tlast -> COMMIT; without tlast -> cfg_err, DRAIN, no write.
//  - DRAIN: accept and discard beats until a tlast beat, then IDLE.
//  - COMMIT (exactly 1 cycle, tready=0): opcode 0x01 -> lookup_din_en=1 and action_en=1, same
//    addr; opcode 0x02 -> action_en=1 only. cfg_cnt+1. Next state IDLE.
//  - Strobe latency: en pulses in the cycle after the final beat handshake.
//  - tready=1 in IDLE/DATA/MASK/DRAIN; 0 in COMMIT. tvalid gaps are tolerated in any state.
//  - Data/mask/addr/action outputs are registered and hold their value after commit until the
//    next commit. Partial staging never alters them: a dropped command leaves them unchanged.
//  - Reset, including mid-command: all outputs 0; FSM to IDLE; staging discarded; no strobe.
//  - cfg_err and a commit never occur in the same cycle.
// TESTING
//  1. Opcode 0x01, stage 0, addr 5, action 0x1ABCDEF, data beats 0x11..,0x22..,0x33..,0x44..,
//     mask beats all-1 -> one cycle with lookup_din_en=action_en=1, addr=5, lookup_din beat
//     order correct, cfg_cnt=1.
//  2. Opcode 0x02, addr 0xF, action 0x3F, tlast on header -> action_en pulse only, action_addr=0xF.
//  3. Header with stage 3 and 9-beat body -> all beats accepted, no strobe, no cfg_err, cfg_cnt unchanged.
//  4. Opcode 0x01 with tlast on 6th beat -> cfg_err pulse, no strobe, outputs hold prior values;
//     next valid command commits normally.
//  5. Random tvalid gaps over test 1 -> identical result; reset asserted after 3rd data beat ->
//     outputs 0, no strobe, FSM accepts a fresh header.

Source files
------------

// File: rtl/lookup_table_writer_if.sv
// AXI4-Stream config channel feeding one stage's lookup_table_writer.
interface lookup_table_writer_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lookup_table_writer.sv
// Parses config commands from the stream and writes TCAM entries / action words
// for the stage matching STAGE; other stages' commands are drained silently.
module lookup_table_writer #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int ENTRY_LEN           = 1024,
  parameter int ACT_LEN             = 25,
  parameter int ADDR_W              = 4,
  parameter int STAGE               = 0
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  lookup_table_writer_if.slave s_axis,
  output logic [ENTRY_LEN-1:0] lookup_din,
  output logic [ENTRY_LEN-1:0] lookup_din_mask,
  output logic [ADDR_W-1:0]    lookup_din_addr,
  output logic                 lookup_din_en,
  output logic [ACT_LEN-1:0]   action_data_in,
  output logic [ADDR_W-1:0]    action_addr,
  output logic                 action_en,
  output logic                 cfg_err,
  output logic [15:0]          cfg_cnt
);

  localparam int W      = C_S_AXIS_DATA_WIDTH;
  localparam int NBEATS = ENTRY_LEN / W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [7:0] OP_ENTRY = 8'h01;
  localparam logic [7:0] OP_ACT   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_MASK,
    S_COMMIT,
    S_DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                op_entry;
  logic [ENTRY_LEN-1:0] data_stg, mask_stg, mask_full;
  logic [ADDR_W-1:0]   addr_stg;
  logic [ACT_LEN-1:0]  act_stg;

  logic                hs, tlast;
  logic [7:0]          hdr_op;
  logic [3:0]          hdr_stage;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [ACT_LEN-1:0]  hdr_act;

  logic err_nxt, hdr_ld, ld_data, ld_mask, commit_entry, commit_act;

  assign hs        = s_axis.tvalid & s_axis.tready;
  assign tlast     = s_axis.tlast;
  assign hdr_op    = s_axis.tdata[W-1 -: 8];
  assign hdr_stage = s_axis.tdata[W-9 -: 4];
  assign hdr_addr  = s_axis.tdata[W-13 -: ADDR_W];
  assign hdr_act   = s_axis.tdata[ACT_LEN-1:0];

  // The last mask beat goes straight into the committed mask, so it is never staged.
  always_comb begin
    mask_full = mask_stg;
    mask_full[(NBEATS-1)*W +: W] = s_axis.tdata;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    err_nxt       = 1'b0;
    hdr_ld        = 1'b0;
    ld_data       = 1'b0;
    ld_mask       = 1'b0;
    commit_entry  = 1'b0;
    commit_act    = 1'b0;
    s_axis.tready = (state != S_COMMIT);
    lookup_din_en = (state == S_COMMIT) && op_entry;
    action_en     = (state == S_COMMIT);

    case (state)
      S_IDLE: begin
        if (hs) begin
          if (hdr_stage != 4'(STAGE)) begin
            state_nxt = tlast ? S_IDLE : S_DRAIN;
          end else if (hdr_op == OP_ACT) begin
            if (tlast) begin
              state_nxt  = S_COMMIT;
              commit_act = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (hdr_op == OP_ENTRY) begin
            if (tlast) begin
              err_nxt = 1'b1;
            end else begin
              state_nxt = S_DATA;
              cnt_nxt   = '0;
              hdr_ld    = 1'b1;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = tlast ? S_IDLE : S_DRAIN;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          if (tlast) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ld_data = 1'b1;
            if (cnt == LAST_BEAT) begin
              state_nxt = S_MASK;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
      end
      S_MASK: begin
        if (hs) begin
          if (cnt == LAST_BEAT) begin
            if (tlast) begin
              state_nxt    = S_COMMIT;
              commit_entry = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (tlast) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ld_mask = 1'b1;
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      S_DRAIN: begin
        if (hs && tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs load on the final handshake so they are valid while the strobes pulse.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      op_entry        <= 1'b0;
      data_stg        <= '0;
      mask_stg        <= '0;
      addr_stg        <= '0;
      act_stg         <= '0;
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      action_data_in  <= '0;
      action_addr     <= '0;
      cfg_err         <= 1'b0;
      cfg_cnt         <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cfg_err <= err_nxt;
      if (hdr_ld) begin
        addr_stg <= hdr_addr;
        act_stg  <= hdr_act;
      end
      if (ld_data) data_stg[int'(cnt)*W +: W] <= s_axis.tdata;
      if (ld_mask) mask_stg[int'(cnt)*W +: W] <= s_axis.tdata;
      if (commit_entry) begin
        lookup_din      <= data_stg;
        lookup_din_mask <= mask_full;
        lookup_din_addr <= addr_stg;
        action_addr     <= addr_stg;
        action_data_in  <= act_stg;
      end
      if (commit_act) begin
        action_addr    <= hdr_addr;
        action_data_in <= hdr_act;
      end
      if (commit_entry || commit_act) begin
        op_entry <= commit_entry;
        cfg_cnt  <= cfg_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lookup_table_writer.sv
// Scoreboard bench for lookup_table_writer: packet-level reference model, random traffic.
module tb_lookup_table_writer;
  localparam int W  = 256;
  localparam int EL = 1024;
  localparam int AL = 25;
  localparam int AW = 4;

  logic axis_clk = 1'b0;
  logic aresetn  = 1'b0;
  always #5 axis_clk = ~axis_clk;

  lookup_table_writer_if #(.DATA_W(W)) s_axis ();

  logic [EL-1:0] lookup_din, lookup_din_mask;
  logic [AW-1:0] lookup_din_addr, action_addr;
  logic          lookup_din_en, action_en, cfg_err;
  logic [AL-1:0] action_data_in;
  logic [15:0]   cfg_cnt;

  lookup_table_writer #(
    .C_S_AXIS_DATA_WIDTH(W),
    .ENTRY_LEN(EL),
    .ACT_LEN(AL),
    .ADDR_W(AW),
    .STAGE(0)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn(aresetn),
    .s_axis(s_axis),
    .lookup_din(lookup_din),
    .lookup_din_mask(lookup_din_mask),
    .lookup_din_addr(lookup_din_addr),
    .lookup_din_en(lookup_din_en),
    .action_data_in(action_data_in),
    .action_addr(action_addr),
    .action_en(action_en),
    .cfg_err(cfg_err),
    .cfg_cnt(cfg_cnt)
  );

  int errors = 0;
  int checks = 0;

  // kind: 0 entry+action commit, 1 action-only commit, 2 cfg_err
  typedef struct {
    int            kind;
    logic [EL-1:0] din;
    logic [EL-1:0] mask;
    logic [AW-1:0] laddr;
    logic [AW-1:0] aaddr;
    logic [AL-1:0] act;
    logic [15:0]   cnt;
  } ev_t;

  ev_t exp_q[$];
  logic [W-1:0] pkt[$];

  // Reference state: what the outputs should show after all issued packets
  logic [EL-1:0] m_din, m_mask;
  logic [AW-1:0] m_laddr, m_aaddr;
  logic [AL-1:0] m_act;
  logic [15:0]   m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [EL-1:0] act, input logic [EL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < EL / W; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s beat %0d: got %h expected %h", name, k, act[k*W +: W], exp[k*W +: W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] mk_hdr(input logic [7:0] op, input logic [3:0] st,
                                          input logic [3:0] ad, input logic [24:0] ac);
    logic [W-1:0] h;
    h = rnd256();
    h[255:248] = op;
    h[247:244] = st;
    h[243:240] = ad;
    h[24:0]    = ac;
    return h;
  endfunction

  function automatic void push_ev(input int kind);
    ev_t e;
    e.kind  = kind;
    e.din   = m_din;
    e.mask  = m_mask;
    e.laddr = m_laddr;
    e.aaddr = m_aaddr;
    e.act   = m_act;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endfunction

  // Whole-packet interpretation: one packet = beats up to and including tlast
  function automatic void model_pkt();
    logic [W-1:0] h;
    int n;
    h = pkt[0];
    n = pkt.size();
    if (h[247:244] != 4'd0) return;
    if (h[255:248] == 8'h02) begin
      if (n == 1) begin
        m_aaddr = h[243:240];
        m_act   = h[24:0];
        m_cnt   = m_cnt + 16'd1;
        push_ev(1);
      end else push_ev(2);
    end else if (h[255:248] == 8'h01) begin
      if (n == 9) begin
        for (int k = 0; k < 4; k++) begin
          m_din[k*W +: W]  = pkt[1+k];
          m_mask[k*W +: W] = pkt[5+k];
        end
        m_laddr = h[243:240];
        m_aaddr = h[243:240];
        m_act   = h[24:0];
        m_cnt   = m_cnt + 16'd1;
        push_ev(0);
      end else push_ev(2);
    end else push_ev(2);
  endfunction

  task automatic hs_wait();
    int n;
    logic rdy;
    n = 0;
    forever begin
      @(negedge axis_clk);
      rdy = s_axis.tready;
      @(posedge axis_clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: tready low for %0d cycles, required 1", n);
        break;
      end
    end
  endtask

  task automatic send(input int gap_pct, input int limit);
    for (int i = 0; i < pkt.size() && i < limit; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_axis.tvalid = 1'b0;
        @(posedge axis_clk);
        #1;
      end
      s_axis.tdata  = pkt[i];
      s_axis.tlast  = (i == pkt.size() - 1);
      s_axis.tvalid = 1'b1;
      hs_wait();
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic run_pkt(input int gap_pct);
    model_pkt();
    send(gap_pct, 1000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  task automatic check_hold(input string tag);
    chk_wide({tag, "_din"}, lookup_din, m_din);
    chk_wide({tag, "_mask"}, lookup_din_mask, m_mask);
    chk({tag, "_laddr"}, 64'(lookup_din_addr), 64'(m_laddr));
    chk({tag, "_aaddr"}, 64'(action_addr), 64'(m_aaddr));
    chk({tag, "_act"}, 64'(action_data_in), 64'(m_act));
    chk({tag, "_cnt"}, 64'(cfg_cnt), 64'(m_cnt));
  endtask

  task automatic build_entry(input logic [3:0] st, input logic [3:0] ad, input logic [24:0] ac,
                             input bit fixed, input int len);
    logic [7:0] b;
    pkt.delete();
    pkt.push_back(mk_hdr(8'h01, st, ad, ac));
    for (int k = 0; k < 4; k++) begin
      b = 8'(8'h11 * (k + 1));
      pkt.push_back(fixed ? {32{b}} : rnd256());
    end
    for (int k = 0; k < 4; k++) pkt.push_back(fixed ? {W{1'b1}} : rnd256());
    while (pkt.size() > len) void'(pkt.pop_back());
    while (pkt.size() < len) pkt.push_back(rnd256());
  endtask

  // Monitor: every strobe or error pulse must match the head of the scoreboard
  ev_t me;
  always @(negedge axis_clk) begin
    if (aresetn && (lookup_din_en || action_en || cfg_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: din_en=%b action_en=%b cfg_err=%b, required no event",
                 lookup_din_en, action_en, cfg_err);
      end else begin
        me = exp_q.pop_front();
        chk("ev_lookup_din_en", 64'(lookup_din_en), 64'(me.kind == 0));
        chk("ev_action_en", 64'(action_en), 64'(me.kind != 2));
        chk("ev_cfg_err", 64'(cfg_err), 64'(me.kind == 2));
        chk_wide("ev_din", lookup_din, me.din);
        chk_wide("ev_mask", lookup_din_mask, me.mask);
        chk("ev_laddr", 64'(lookup_din_addr), 64'(me.laddr));
        chk("ev_aaddr", 64'(action_addr), 64'(me.aaddr));
        chk("ev_act", 64'(action_data_in), 64'(me.act));
        chk("ev_cnt", 64'(cfg_cnt), 64'(me.cnt));
      end
    end
  end

  initial begin
    int kind, len;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_din = '0; m_mask = '0; m_laddr = '0; m_aaddr = '0; m_act = '0; m_cnt = '0;
    idle(3);
    check_hold("reset");
    chk("reset_strobes", 64'({lookup_din_en, action_en, cfg_err}), 64'(0));
    aresetn = 1'b1;
    idle(2);

    // Entry+action write with fixed beat pattern
    build_entry(4'd0, 4'd5, 25'h1ABCDEF, 1'b1, 9);
    run_pkt(0);
    idle(3);
    chk("t1_din_beat0", 64'(lookup_din[63:0]), {8{8'h11}});
    chk("t1_din_beat3", 64'(lookup_din[1023:960]), {8{8'h44}});
    chk("t1_cnt", 64'(cfg_cnt), 64'(1));

    // Action-only write
    pkt.delete();
    pkt.push_back(mk_hdr(8'h02, 4'd0, 4'hF, 25'h3F));
    run_pkt(0);
    idle(3);
    chk("t2_aaddr", 64'(action_addr), 64'hF);

    // Foreign stage: drained, no event
    build_entry(4'd3, 4'd2, 25'h55, 1'b0, 9);
    run_pkt(0);
    idle(3);
    check_hold("t3");

    // Early tlast on 6th beat, then a good command
    build_entry(4'd0, 4'd7, 25'h1234, 1'b0, 6);
    run_pkt(0);
    idle(3);
    check_hold("t4_hold");
    build_entry(4'd0, 4'd9, 25'h0ABCDE, 1'b0, 9);
    run_pkt(0);
    idle(3);

    // Gapped repeat of the first command
    build_entry(4'd0, 4'd5, 25'h1ABCDEF, 1'b1, 9);
    run_pkt(40);
    idle(3);
    check_hold("t5_gap");

    // Reset after 3rd data beat
    build_entry(4'd0, 4'd3, 25'h777, 1'b0, 9);
    send(0, 4);
    aresetn = 1'b0;
    #2;
    m_din = '0; m_mask = '0; m_laddr = '0; m_aaddr = '0; m_act = '0; m_cnt = '0;
    check_hold("t5_reset");
    chk("t5_reset_strobes", 64'({lookup_din_en, action_en, cfg_err}), 64'(0));
    idle(2);
    aresetn = 1'b1;
    idle(1);
    build_entry(4'd0, 4'd6, 25'h1F00F, 1'b0, 9);
    run_pkt(0);
    idle(3);
    check_hold("t5_fresh");

    // Randomised traffic
    for (int p = 0; p < 80; p++) begin
      kind = int'($urandom_range(7));
      case (kind)
        0, 1: build_entry(4'd0, 4'($urandom), 25'($urandom), 1'b0, 9);
        2: begin
          pkt.delete();
          pkt.push_back(mk_hdr(8'h02, 4'd0, 4'($urandom), 25'($urandom)));
        end
        3: build_entry(4'($urandom_range(1, 15)), 4'($urandom), 25'($urandom), 1'b0,
                       int'($urandom_range(1, 11)));
        4: begin
          len = int'($urandom_range(1, 4));
          pkt.delete();
          pkt.push_back(mk_hdr(8'($urandom_range(3, 255)), 4'd0, 4'($urandom), 25'($urandom)));
          while (pkt.size() < len) pkt.push_back(rnd256());
        end
        5: build_entry(4'd0, 4'($urandom), 25'($urandom), 1'b0, int'($urandom_range(1, 8)));
        6: build_entry(4'd0, 4'($urandom), 25'($urandom), 1'b0, int'($urandom_range(10, 12)));
        default: begin
          len = int'($urandom_range(2, 3));
          pkt.delete();
          pkt.push_back(mk_hdr(8'h02, 4'd0, 4'($urandom), 25'($urandom)));
          while (pkt.size() < len) pkt.push_back(rnd256());
        end
      endcase
      run_pkt(int'($urandom_range(0, 50)));
    end

    idle(5);
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check_hold("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
